// File: rtl/ec2_loader_pkg.sv
// Shared encodings and sizes for the EC2 program loader.
package ec2_loader_pkg;

  localparam int MEM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int COUNT_W   = 5;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    WAITKEY = 3'd1,
    WRITE   = 3'd2,
    WAITREL = 3'd3,
    RUN     = 3'd4,
    HALTED  = 3'd5
  } state_t;

  // The CPU is only released while executing or showing its halted result.
  function automatic logic holds_cpu_reset(input state_t s);
    return !((s == RUN) || (s == HALTED));
  endfunction

endpackage

// File: rtl/ec2_program_loader_enter_sync.sv
// Two-flop synchroniser for the raw Enter button plus a rising-edge detector.
module enter_sync
  import ec2_loader_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic Enter,
  output logic EnterSync,
  output logic EnterEdge
);

  logic meta;
  logic sync;
  logic sync_prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      meta      <= Enter;
      sync      <= meta;
      sync_prev <= sync;
    end
  end

  assign EnterSync = sync;
  assign EnterEdge = sync & ~sync_prev;

endmodule

// File: rtl/ec2_program_loader.sv
// Front-panel program loader: writes switch bytes into 16-entry program memory
// on Enter presses and holds the CPU in reset until the program is run.
module ec2_program_loader
  import ec2_loader_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Load,
  input  logic                Run,
  input  logic                Enter,
  input  logic [DATA_W-1:0]   Input,
  input  logic                Halt,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemData,
  output logic                MemWr,
  output logic                CpuReset,
  output logic [COUNT_W-1:0]  Count,
  output logic [STATE_W-1:0]  State
);

  state_t               state_reg;
  state_t               state_next;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    data_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 enter_sync_level;
  logic                 enter_edge;
  logic                 start_session;
  logic                 capture;
  logic                 advance;
  logic                 mem_wr;
  logic                 cpu_reset;

  enter_sync u_enter_sync (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enter     (Enter),
    .EnterSync (enter_sync_level),
    .EnterEdge (enter_edge)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    start_session = 1'b0;
    capture       = 1'b0;
    advance       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Run) begin
          state_next = RUN;
        end else if (Load) begin
          state_next    = WAITKEY;
          start_session = 1'b1;
        end
      end
      WAITKEY: begin
        if (Run) begin
          state_next = RUN;
        end else if (enter_edge) begin
          state_next = WRITE;
          capture    = 1'b1;
        end
      end
      WRITE: begin
        state_next = WAITREL;
        advance    = 1'b1;
      end
      WAITREL: begin
        // Wait for release so a held button yields a single write.
        if (!enter_sync_level)
          state_next = (count_reg == COUNT_W'(MEM_DEPTH)) ? RUN : WAITKEY;
      end
      RUN: begin
        if (Load) begin
          state_next    = WAITKEY;
          start_session = 1'b1;
        end else if (Halt) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (Load) begin
          state_next    = WAITKEY;
          start_session = 1'b1;
        end else if (Run) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_wr    = (state_reg == WRITE);
    cpu_reset = holds_cpu_reset(state_reg);
  end

  // Address and data stay put between writes so the panel keeps showing them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (start_session) begin
        addr_reg  <= '0;
        count_reg <= '0;
      end
      if (capture)
        data_reg <= Input;
      if (advance) begin
        addr_reg  <= addr_reg + ADDR_W'(1);
        count_reg <= count_reg + COUNT_W'(1);
      end
    end
  end

  assign MemAddr  = addr_reg;
  assign MemData  = data_reg;
  assign MemWr    = mem_wr;
  assign CpuReset = cpu_reset;
  assign Count    = count_reg;
  assign State    = state_reg;

endmodule

// File: doc/ec2_program_loader.md
EC2_PROGRAM_LOADER -- requirements
Module: ec2_program_loader

Interface
REQ-001 SHALL have port Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port Load  in  1  level; request to enter program-load mode.
REQ-004 SHALL have port Run  in  1  level; request to release the CPU and execute.
REQ-005 SHALL have port Enter  in  1  raw push-button, active-high, asynchronous to Clock.
REQ-006 SHALL have port Input  in  8  switch byte written to program memory.
REQ-007 SHALL have port Halt  in  1  CPU halt indication from the control unit.
REQ-008 SHALL have port MemAddr  out  4  program-memory write address.
REQ-009 SHALL have port MemData  out  8  program-memory write data.
REQ-010 SHALL have port MemWr  out  1  one-cycle memory write strobe.
REQ-011 SHALL have port CpuReset  out  1  holds CPU (CU and DP) in reset while high.
REQ-012 SHALL have port Count  out  5  number of bytes written this load session, 0..16.
REQ-013 SHALL have port State  out  3  current FSM state encoding, for display.

Function
REQ-014 SHALL implement states IDLE=0, WAITKEY=1, WRITE=2, WAITREL=3, RUN=4, HALTED=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-015 SHALL synchronise Enter through two flops, then form EnterEdge = sync high and previous sync low.
REQ-016 IDLE: Run=1 -> RUN; else Load=1 -> WAITKEY with MemAddr=0, Count=0; Run has priority.
REQ-017 WAITKEY: Run=1 -> RUN (early finish); else EnterEdge -> WRITE and MemData captures Input in that same cycle.
REQ-018 WRITE: MemWr=1 for exactly this one cycle with current MemAddr/MemData; next -> WAITREL; Count increments; MemAddr increments modulo 16.
REQ-019 WAITREL: stays until synchronised Enter=0; then -> RUN if Count=16, else -> WAITKEY.
REQ-020 After the 16th write MemAddr SHALL wrap to 0; no further writes occur in that session.
REQ-021 RUN: Load=1 -> WAITKEY (MemAddr=0, Count=0); else Halt=1 -> HALTED.
REQ-022 HALTED: Load=1 -> WAITKEY (MemAddr=0, Count=0); else Run=1 -> IDLE; CPU Output remains visible.
REQ-023 CpuReset SHALL be 1 in IDLE, WAITKEY, WRITE, WAITREL and 0 in RUN, HALTED (Moore, registered state decode).
REQ-024 MemWr SHALL be 0 in every state except WRITE; MemAddr/MemData SHALL hold between writes.
REQ-025 Latency: Enter high sampled at edge N -> EnterEdge at N+2 -> WRITE state (MemWr=1) during cycle N+3.
REQ-026 Held Enter SHALL produce exactly one write; bounce is out of scope (debounce upstream).
REQ-027 Halt SHALL be ignored in all states except RUN.

Reset
REQ-028 Reset=1 SHALL immediately force State=IDLE, MemAddr=0, MemData=0, Count=0, MemWr=0, CpuReset=1, synchroniser flops=0.
REQ-029 Reset mid-WRITE SHALL abort the strobe asynchronously; no partial-session state survives.

Structure
REQ-030 Package ec2_loader_pkg SHALL hold state encodings, MEM_DEPTH=16, ADDR_W=4, DATA_W=8.
REQ-031 Synchroniser plus edge detector SHALL be sub-module enter_sync (ports Clock, Reset, Enter, EnterSync, EnterEdge).

Verification
REQ-032 Reset, Load=1 one cycle, 16 press/release cycles with Input=0x10..0x1F -> 16 MemWr pulses, addr 0..15 data 0x10..0x1F, then RUN, CpuReset=0, Count=16.
REQ-033 Load, 3 presses (0xA1,0xB2,0xC3), Run=1 in WAITKEY -> RUN with Count=3, MemAddr=3, no 4th write.
REQ-034 Enter held high 20 cycles in WAITKEY -> exactly one MemWr, State stays WAITREL until Enter low.
REQ-035 RUN then Halt=1 -> HALTED, CpuReset=0; Run=1 -> IDLE one cycle (CpuReset=1) -> RUN.
REQ-036 Run and Load both 1 in IDLE -> RUN; Load=1 in HALTED -> WAITKEY, Count=0, MemAddr=0.
REQ-037 Reset asserted during WRITE of byte 5 -> MemWr falls without a clock edge, IDLE, Count=0, CpuReset=1.
